// File: rtl/mem_arbiter.sv
// Arbiter for the memory controller's single request channel: the LSB has priority,
// instruction fetch is protected against starvation, and fetches abort on a jump.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_flag,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_rdata,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  input  logic [2:0]  lsb_size,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic        mc_valid,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [2:0]  mc_size,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GRANT_IC  = 2'd1;
  localparam logic [1:0] GRANT_LSB = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             mc_valid_reg, mc_valid_next;
  logic             mc_wr_reg, mc_wr_next;
  logic [31:0]      mc_addr_reg, mc_addr_next;
  logic [31:0]      mc_wdata_reg, mc_wdata_next;
  logic [2:0]       mc_size_reg, mc_size_next;
  logic             ic_done_reg, ic_done_next;
  logic             lsb_done_reg, lsb_done_next;
  logic [31:0]      ic_rdata_reg, ic_rdata_next;
  logic [31:0]      lsb_rdata_reg, lsb_rdata_next;
  logic             starved;

  assign starved = ic_req && (starve_cnt_reg >= LIMIT);

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    mc_valid_next   = mc_valid_reg;
    mc_wr_next      = mc_wr_reg;
    mc_addr_next    = mc_addr_reg;
    mc_wdata_next   = mc_wdata_reg;
    mc_size_next    = mc_size_reg;
    ic_done_next    = 1'b0;
    lsb_done_next   = 1'b0;
    ic_rdata_next   = ic_rdata_reg;
    lsb_rdata_next  = lsb_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (lsb_req && !starved) begin
          state_next    = GRANT_LSB;
          mc_valid_next = 1'b1;
          mc_wr_next    = lsb_wr;
          mc_addr_next  = lsb_addr;
          mc_wdata_next = lsb_wdata;
          mc_size_next  = lsb_size;
          if (ic_req && (starve_cnt_reg != CNT_MAX))
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end else if (ic_req && !jump_flag) begin
          state_next      = GRANT_IC;
          mc_valid_next   = 1'b1;
          mc_wr_next      = 1'b0;
          mc_addr_next    = ic_addr;
          mc_wdata_next   = 32'd0;
          mc_size_next    = 3'd4;
          starve_cnt_next = '0;
        end
      end
      GRANT_IC: begin
        // An abort wins over a coincident completion: the fetched word is stale.
        if (jump_flag || !ic_req) begin
          state_next    = GAP;
          mc_valid_next = 1'b0;
        end else if (mc_done) begin
          state_next    = GAP;
          mc_valid_next = 1'b0;
          ic_done_next  = 1'b1;
          ic_rdata_next = mc_rdata;
        end
      end
      GRANT_LSB: begin
        if (mc_done) begin
          state_next     = GAP;
          mc_valid_next  = 1'b0;
          lsb_done_next  = 1'b1;
          lsb_rdata_next = mc_rdata;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      mc_valid_reg   <= 1'b0;
      mc_wr_reg      <= 1'b0;
      mc_addr_reg    <= 32'd0;
      mc_wdata_reg   <= 32'd0;
      mc_size_reg    <= 3'd0;
      ic_done_reg    <= 1'b0;
      lsb_done_reg   <= 1'b0;
      ic_rdata_reg   <= 32'd0;
      lsb_rdata_reg  <= 32'd0;
    end else if (rdy) begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      mc_valid_reg   <= mc_valid_next;
      mc_wr_reg      <= mc_wr_next;
      mc_addr_reg    <= mc_addr_next;
      mc_wdata_reg   <= mc_wdata_next;
      mc_size_reg    <= mc_size_next;
      ic_done_reg    <= ic_done_next;
      lsb_done_reg   <= lsb_done_next;
      ic_rdata_reg   <= ic_rdata_next;
      lsb_rdata_reg  <= lsb_rdata_next;
    end else begin
      // Frozen: everything holds except the done strobes, which must not repeat.
      ic_done_reg  <= 1'b0;
      lsb_done_reg <= 1'b0;
    end
  end

  assign mc_valid  = mc_valid_reg;
  assign mc_wr     = mc_wr_reg;
  assign mc_addr   = mc_addr_reg;
  assign mc_wdata  = mc_wdata_reg;
  assign mc_size   = mc_size_reg;
  assign ic_done   = ic_done_reg;
  assign ic_rdata  = ic_rdata_reg;
  assign lsb_done  = lsb_done_reg;
  assign lsb_rdata = lsb_rdata_reg;

endmodule
